// File: rtl/lcd_pkg.sv
// Shared colour constants, timing description and helpers for the LCD
// register-grid display.
package lcd_pkg;

    typedef logic [15:0] rgb565_t;

    localparam rgb565_t COL_BLACK  = 16'h0000;
    localparam rgb565_t COL_WHITE  = 16'hFFFF;
    localparam rgb565_t COL_BLUE   = 16'h001F;
    localparam rgb565_t COL_YELLOW = 16'hFFE0;
    localparam rgb565_t COL_RED    = 16'hF800;

    typedef struct packed {
        logic [15:0] sync;
        logic [15:0] bp;
        logic [15:0] active;
        logic [15:0] fp;
    } lcd_timing_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int timing_total(input lcd_timing_t t);
        return int'(t.sync) + int'(t.bp) + int'(t.active) + int'(t.fp);
    endfunction

    // First counter value of the visible region
    function automatic int active_start(input lcd_timing_t t);
        return int'(t.sync) + int'(t.bp);
    endfunction

endpackage

// File: rtl/lcd_timing_gen.sv
// Horizontal/vertical counters with the combinational sync, data-enable and
// active-area coordinate decode that feeds the grid pipeline.
module lcd_timing_gen
    import lcd_pkg::*;
#(
    parameter int H_SYNC   = 1,
    parameter int H_BP     = 182,
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 210,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 0,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 45
) (
    input  logic        PixelClk,
    input  logic        nRST,
    output logic        hs_n,
    output logic        vs_n,
    output logic        de,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        sof,
    output logic        eof
);

    localparam lcd_timing_t HT = '{
        sync:   16'(H_SYNC),
        bp:     16'(H_BP),
        active: 16'(H_ACTIVE),
        fp:     16'(H_FP)
    };
    localparam lcd_timing_t VT = '{
        sync:   16'(V_SYNC),
        bp:     16'(V_BP),
        active: 16'(V_ACTIVE),
        fp:     16'(V_FP)
    };

    localparam logic [15:0] H_LAST = 16'(timing_total(HT) - 1);
    localparam logic [15:0] V_LAST = 16'(timing_total(VT) - 1);
    localparam logic [15:0] H_ACT0 = 16'(active_start(HT));
    localparam logic [15:0] H_ACT1 = 16'(active_start(HT) + H_ACTIVE);
    localparam logic [15:0] V_ACT0 = 16'(active_start(VT));
    localparam logic [15:0] V_ACT1 = 16'(active_start(VT) + V_ACTIVE);

    if (timing_total(HT) < 1 || timing_total(HT) > 65536) begin : g_bad_htotal
        $error("lcd_timing_gen: horizontal total must be 1..65536");
    end
    if (timing_total(VT) < 1 || timing_total(VT) > 65536) begin : g_bad_vtotal
        $error("lcd_timing_gen: vertical total must be 1..65536");
    end

    logic [15:0] hcnt;
    logic [15:0] vcnt;

    // The line counter only advances on the last pixel of each line
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            if (vcnt == V_LAST) begin
                vcnt <= '0;
            end else begin
                vcnt <= vcnt + 16'd1;
            end
        end else begin
            hcnt <= hcnt + 16'd1;
        end
    end

    always_comb begin
        hs_n = (hcnt >= HT.sync);
        vs_n = (vcnt >= VT.sync);
        de   = (hcnt >= H_ACT0) && (hcnt < H_ACT1) &&
               (vcnt >= V_ACT0) && (vcnt < V_ACT1);
        x    = hcnt - H_ACT0;
        y    = vcnt - V_ACT0;
        sof  = (hcnt == 16'd0) && (vcnt == 16'd0);
        eof  = (hcnt == H_LAST) && (vcnt == V_LAST);
    end

endmodule

// File: rtl/lcd_reg_grid_display.sv
// LCD timing generator with a register-grid overlay: each register is a row of
// square cells, MSB on the left, with a blinking cursor row and a frame strobe.
module lcd_reg_grid_display
    import lcd_pkg::*;
#(
    parameter int H_SYNC     = 1,
    parameter int H_BP       = 182,
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 210,
    parameter int V_SYNC     = 5,
    parameter int V_BP       = 0,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 45,
    parameter int NREGS      = 8,
    parameter int NBITS      = 4,
    parameter int CELL_LOG2  = 5,
    parameter int ORG_X      = 128,
    parameter int ORG_Y      = 8,
    parameter int BLINK_LOG2 = 5,
    localparam int RSW       = (NREGS > 1) ? clog2(NREGS) : 1
) (
    input  logic             PixelClk,
    input  logic             nRST,
    input  logic             cursor_en,
    input  logic [7:0]       cursor_row,
    output logic [RSW-1:0]   regsel,
    input  logic [NBITS-1:0] regdat,
    output logic             LCD_HSYNC,
    output logic             LCD_VSYNC,
    output logic             LCD_DE,
    output logic [4:0]       LCD_R,
    output logic [5:0]       LCD_G,
    output logic [4:0]       LCD_B,
    output logic             frame_start
);

    localparam int BW = (NBITS > 1) ? clog2(NBITS) : 1;
    localparam logic [15:0] ORG_X16 = 16'(ORG_X);
    localparam logic [15:0] ORG_Y16 = 16'(ORG_Y);

    if (NREGS > 256 || NREGS < 1) begin : g_bad_nregs
        $error("lcd_reg_grid_display: NREGS must be 1..256");
    end
    if (NBITS < 1 || NBITS > 32) begin : g_bad_nbits
        $error("lcd_reg_grid_display: NBITS must be 1..32");
    end
    if (CELL_LOG2 < 3 || CELL_LOG2 > 7) begin : g_bad_cell
        $error("lcd_reg_grid_display: CELL_LOG2 must be 3..7");
    end
    if (BLINK_LOG2 < 1) begin : g_bad_blink
        $error("lcd_reg_grid_display: BLINK_LOG2 must be at least 1");
    end

    logic        hs0_n;
    logic        vs0_n;
    logic        de0;
    logic        sof0;
    logic        eof0;
    logic [15:0] x0;
    logic [15:0] y0;

    lcd_timing_gen #(
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP)
    ) u_timing (
        .PixelClk (PixelClk),
        .nRST     (nRST),
        .hs_n     (hs0_n),
        .vs_n     (vs0_n),
        .de       (de0),
        .x        (x0),
        .y        (y0),
        .sof      (sof0),
        .eof      (eof0)
    );

    logic [15:0]   xr;
    logic [15:0]   yr;
    logic [15:0]   col;
    logic [15:0]   row;
    logic          in_grid;
    logic          gap;
    logic          lit0;
    logic          match0;
    logic [BW-1:0] bitidx0;

    // Grid-relative coordinates wrap when left of / above the origin, so the
    // origin comparisons are what keep those pixels out of the grid
    always_comb begin
        xr      = x0 - ORG_X16;
        yr      = y0 - ORG_Y16;
        col     = xr >> CELL_LOG2;
        row     = yr >> CELL_LOG2;
        in_grid = de0 && (x0 >= ORG_X16) && (y0 >= ORG_Y16) &&
                  (32'(col) < NBITS) && (32'(row) < NREGS);
        gap     = (xr[CELL_LOG2-1 -: 3] == 3'd0) || (yr[CELL_LOG2-1 -: 2] == 2'd0);
        lit0    = in_grid && !gap;
        bitidx0 = BW'(NBITS - 1) - col[BW-1:0];
        match0  = (row == {8'd0, cursor_row});
    end

    logic [BLINK_LOG2-1:0] frame_cnt;

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            frame_cnt <= '0;
        end else if (eof0) begin
            frame_cnt <= frame_cnt + BLINK_LOG2'(1);
        end
    end

    logic          hs1_n;
    logic          vs1_n;
    logic          de1;
    logic          lit1;
    logic          hl1;
    logic          sof1;
    logic [BW-1:0] bitidx1;

    // Stage 1: regsel goes out to the external mux; the highlight decision is
    // taken here so the blink phase belongs to the frame of this pixel
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            hs1_n   <= 1'b1;
            vs1_n   <= 1'b1;
            de1     <= 1'b0;
            lit1    <= 1'b0;
            hl1     <= 1'b0;
            sof1    <= 1'b0;
            bitidx1 <= '0;
            regsel  <= '0;
        end else begin
            hs1_n   <= hs0_n;
            vs1_n   <= vs0_n;
            de1     <= de0;
            lit1    <= lit0;
            hl1     <= cursor_en && match0 && frame_cnt[BLINK_LOG2-1];
            sof1    <= sof0;
            bitidx1 <= bitidx0;
            regsel  <= in_grid ? row[RSW-1:0] : '0;
        end
    end

    logic    pix_bit;
    rgb565_t colour;

    always_comb begin
        pix_bit = regdat[bitidx1];
        colour  = COL_BLACK;
        if (de1 && lit1) begin
            if (hl1) begin
                colour = pix_bit ? COL_YELLOW : COL_RED;
            end else begin
                colour = pix_bit ? COL_WHITE : COL_BLUE;
            end
        end
    end

    // Stage 2: every panel output leaves from a flop, two clocks after its counter state
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            LCD_HSYNC   <= 1'b1;
            LCD_VSYNC   <= 1'b1;
            LCD_DE      <= 1'b0;
            LCD_R       <= '0;
            LCD_G       <= '0;
            LCD_B       <= '0;
            frame_start <= 1'b0;
        end else begin
            LCD_HSYNC   <= hs1_n;
            LCD_VSYNC   <= vs1_n;
            LCD_DE      <= de1;
            LCD_R       <= colour[15:11];
            LCD_G       <= colour[10:5];
            LCD_B       <= colour[4:0];
            frame_start <= sof1;
        end
    end

endmodule

// File: tb/tb_lcd_reg_grid_display.sv
// Randomised bench for lcd_reg_grid_display on a small panel: a frame-level
// model predicts every output each cycle, plus literal timing/colour pins.
module tb_lcd_reg_grid_display;

    localparam int H_SYNC     = 1;
    localparam int H_BP       = 2;
    localparam int H_ACTIVE   = 32;
    localparam int H_FP       = 3;
    localparam int V_SYNC     = 1;
    localparam int V_BP       = 1;
    localparam int V_ACTIVE   = 16;
    localparam int V_FP       = 2;
    localparam int NREGS      = 2;
    localparam int NBITS      = 4;
    localparam int CELL_LOG2  = 3;
    localparam int ORG_X      = 4;
    localparam int ORG_Y      = 2;
    localparam int BLINK_LOG2 = 2;

    localparam int HT    = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int VT    = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int FRAME = HT * VT;
    localparam int CELL  = 1 << CELL_LOG2;
    localparam int HA0   = H_SYNC + H_BP;
    localparam int VA0   = V_SYNC + V_BP;

    logic             PixelClk = 1'b0;
    logic             nRST     = 1'b0;
    logic             cursor_en;
    logic [7:0]       cursor_row;
    logic [0:0]       regsel;
    logic [NBITS-1:0] regdat;
    logic             LCD_HSYNC;
    logic             LCD_VSYNC;
    logic             LCD_DE;
    logic [4:0]       LCD_R;
    logic [5:0]       LCD_G;
    logic [4:0]       LCD_B;
    logic             frame_start;

    logic [NBITS-1:0] regs [NREGS];
    int edges;
    int checks = 0;
    int errors = 0;
    logic checkEn = 1'b0;
    logic directed = 1'b1;
    int fsFirst, fsSecond, deFirst, hsLow, vsLow, deHigh;

    lcd_reg_grid_display #(
        .H_SYNC     (H_SYNC),
        .H_BP       (H_BP),
        .H_ACTIVE   (H_ACTIVE),
        .H_FP       (H_FP),
        .V_SYNC     (V_SYNC),
        .V_BP       (V_BP),
        .V_ACTIVE   (V_ACTIVE),
        .V_FP       (V_FP),
        .NREGS      (NREGS),
        .NBITS      (NBITS),
        .CELL_LOG2  (CELL_LOG2),
        .ORG_X      (ORG_X),
        .ORG_Y      (ORG_Y),
        .BLINK_LOG2 (BLINK_LOG2)
    ) dut (
        .PixelClk    (PixelClk),
        .nRST        (nRST),
        .cursor_en   (cursor_en),
        .cursor_row  (cursor_row),
        .regsel      (regsel),
        .regdat      (regdat),
        .LCD_HSYNC   (LCD_HSYNC),
        .LCD_VSYNC   (LCD_VSYNC),
        .LCD_DE      (LCD_DE),
        .LCD_R       (LCD_R),
        .LCD_G       (LCD_G),
        .LCD_B       (LCD_B),
        .frame_start (frame_start)
    );

    always #5 PixelClk = ~PixelClk;

    // External register file: a plain combinational read of the selected row
    assign regdat = regs[regsel];

    always @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            edges <= 0;
        end else begin
            edges <= edges + 1;
        end
    end

    // Expected panel outputs for the s-th pixel clock since reset, from the frame geometry
    function automatic void model(input int s, output logic ehs, output logic evs,
                                  output logic ede, output logic efs,
                                  output logic [15:0] ergb, output int esel);
        int h, v, f, x, y, col, row;
        logic ingrid, gap, b, hl;
        h   = s % HT;
        v   = (s / HT) % VT;
        f   = s / FRAME;
        x   = h - HA0;
        y   = v - VA0;
        ehs = (h >= H_SYNC);
        evs = (v >= V_SYNC);
        ede = (x >= 0) && (x < H_ACTIVE) && (y >= 0) && (y < V_ACTIVE);
        efs = (s % FRAME) == 0;
        col = (x - ORG_X) / CELL;
        row = (y - ORG_Y) / CELL;
        ingrid = ede && (x >= ORG_X) && (y >= ORG_Y) && (col < NBITS) && (row < NREGS);
        gap  = (((x - ORG_X) % CELL) < CELL / 8) || (((y - ORG_Y) % CELL) < CELL / 4);
        esel = ingrid ? row : 0;
        ergb = 16'h0000;
        if (ingrid && !gap) begin
            b  = regs[row][NBITS-1-col];
            hl = cursor_en && (int'(cursor_row) == row) &&
                 (((f / (1 << (BLINK_LOG2 - 1))) % 2) == 1);
            if (hl) begin
                ergb = b ? 16'hFFE0 : 16'hF800;
            end else begin
                ergb = b ? 16'hFFFF : 16'h001F;
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, edges);
        end
    endtask

    // Registers and cursor only change on the sync line, so nothing in flight sees the change
    task automatic applyStimulus();
        int h, v, f;
        h = edges % HT;
        v = (edges / HT) % VT;
        f = edges / FRAME;
        if (v == 0 && h == 2) begin
            if (directed && f < 6) begin
                regs[0] = 4'hA;
                regs[1] = 4'h5;
                cursor_en = 1'b1;
                cursor_row = 8'd1;
            end else if (directed && f < 8) begin
                cursor_en = 1'b1;
                cursor_row = 8'd5;
            end else begin
                for (int i = 0; i < NREGS; i++) begin
                    regs[i] = NBITS'($urandom_range(0, (1 << NBITS) - 1));
                end
                cursor_en = 1'($urandom_range(0, 1));
                cursor_row = 8'($urandom_range(0, 3));
                if (cursor_row == 8'd3) begin
                    cursor_row = 8'd200;
                end
            end
        end
    endtask

    task automatic pinModel();
        logic ehs, evs, ede, efs;
        logic [15:0] ergb;
        int esel;
        model(6 * HT + 8, ehs, evs, ede, efs, ergb, esel);
        checkOutput("pin_row0_col0_white", 32'(ergb), 32'h0000FFFF);
        model(6 * HT + 16, ehs, evs, ede, efs, ergb, esel);
        checkOutput("pin_row0_col1_blue", 32'(ergb), 32'h0000001F);
        model(6 * HT + 15, ehs, evs, ede, efs, ergb, esel);
        checkOutput("pin_xgap_black", 32'(ergb), 32'h00000000);
        model(5 * HT + 8, ehs, evs, ede, efs, ergb, esel);
        checkOutput("pin_ygap_black", 32'(ergb), 32'h00000000);
        model(2 * FRAME + 14 * HT + 8, ehs, evs, ede, efs, ergb, esel);
        checkOutput("pin_cursor_red", 32'(ergb), 32'h0000F800);
        checkOutput("pin_cursor_sel", esel, 1);
        model(2 * FRAME + 14 * HT + 16, ehs, evs, ede, efs, ergb, esel);
        checkOutput("pin_cursor_yellow", 32'(ergb), 32'h0000FFE0);
        model(FRAME + 14 * HT + 16, ehs, evs, ede, efs, ergb, esel);
        checkOutput("pin_noblink_white", 32'(ergb), 32'h0000FFFF);
        model(6 * HT + 35, ehs, evs, ede, efs, ergb, esel);
        checkOutput("pin_clip_black", 32'(ergb), 32'h00000000);
        checkOutput("pin_clip_de", 32'(ede), 32'd0);
        model(HT, ehs, evs, ede, efs, ergb, esel);
        checkOutput("pin_hsync_low", 32'(ehs), 32'd0);
        model(FRAME, ehs, evs, ede, efs, ergb, esel);
        checkOutput("pin_frame_start", 32'(efs), 32'd1);
    endtask

    task automatic clearStats();
        fsFirst  = -1;
        fsSecond = -1;
        deFirst  = -1;
        hsLow    = 0;
        vsLow    = 0;
        deHigh   = 0;
    endtask

    task automatic checkStats(input string tag);
        checkOutput({tag, "_first_frame_start"}, fsFirst, 2);
        checkOutput({tag, "_frame_period"}, fsSecond - fsFirst, 760);
        checkOutput({tag, "_first_de"}, deFirst, 81);
        checkOutput({tag, "_hsync_low_clks"}, hsLow, 20);
        checkOutput({tag, "_vsync_low_clks"}, vsLow, 38);
        checkOutput({tag, "_de_high_clks"}, deHigh, 512);
    endtask

    initial begin : compare_proc
        logic ehs, evs, ede, efs, dhs, dvs, dde, dfs;
        logic [15:0] ergb, drgb;
        int esel, dsel;
        forever begin
            @(negedge PixelClk);
            if (nRST && checkEn) begin
                if (edges >= 2) begin
                    model(edges - 2, ehs, evs, ede, efs, ergb, dsel);
                end else begin
                    ehs = 1'b1;
                    evs = 1'b1;
                    ede = 1'b0;
                    efs = 1'b0;
                    ergb = 16'h0000;
                end
                if (edges >= 1) begin
                    model(edges - 1, dhs, dvs, dde, dfs, drgb, esel);
                end else begin
                    esel = 0;
                end
                checkOutput("hsync", 32'(LCD_HSYNC), 32'(ehs));
                checkOutput("vsync", 32'(LCD_VSYNC), 32'(evs));
                checkOutput("de", 32'(LCD_DE), 32'(ede));
                checkOutput("rgb", 32'({LCD_R, LCD_G, LCD_B}), 32'(ergb));
                checkOutput("frame_start", 32'(frame_start), 32'(efs));
                checkOutput("regsel", 32'(regsel), esel);
                if (frame_start === 1'b1) begin
                    if (fsFirst < 0) fsFirst = edges;
                    else if (fsSecond < 0) fsSecond = edges;
                end
                if (LCD_DE === 1'b1 && deFirst < 0) deFirst = edges;
                if (edges >= 2 && edges < 2 + FRAME) begin
                    if (LCD_HSYNC === 1'b0) hsLow++;
                    if (LCD_VSYNC === 1'b0) vsLow++;
                    if (LCD_DE === 1'b1) deHigh++;
                end
            end
        end
    end

    initial begin
        logic found;
        regs[0] = 4'hA;
        regs[1] = 4'h5;
        cursor_en = 1'b1;
        cursor_row = 8'd1;
        clearStats();
        pinModel();

        #12;
        nRST = 1'b1;
        checkEn = 1'b1;
        repeat (8 * FRAME) begin
            @(posedge PixelClk);
            #1;
            applyStimulus();
        end
        checkStats("powerup");

        // Reset in the middle of a lit grid line
        directed = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(posedge PixelClk);
            #1;
            applyStimulus();
            if ((edges % HT) == HA0 + 10 && ((edges / HT) % VT) == VA0 + ORG_Y + 3) found = 1'b1;
        end
        checkOutput("reset_point_found", 32'(found), 32'd1);
        checkOutput("pre_reset_de", 32'(LCD_DE), 32'd1);
        #1;
        nRST = 1'b0;
        #1;
        checkOutput("rst_hsync", 32'(LCD_HSYNC), 32'd1);
        checkOutput("rst_vsync", 32'(LCD_VSYNC), 32'd1);
        checkOutput("rst_de", 32'(LCD_DE), 32'd0);
        checkOutput("rst_rgb", 32'({LCD_R, LCD_G, LCD_B}), 32'd0);
        checkOutput("rst_frame_start", 32'(frame_start), 32'd0);
        checkOutput("rst_regsel", 32'(regsel), 32'd0);
        clearStats();
        repeat (3) @(posedge PixelClk);
        @(negedge PixelClk);
        #2;
        nRST = 1'b1;
        repeat (3 * FRAME) begin
            @(posedge PixelClk);
            #1;
            applyStimulus();
        end
        checkStats("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
